// File: rtl/ovsf_chip_spreader_pkg.sv
// Shared definitions for the transmit chain: sample width, spreader state type
// and a generic bit-reversal helper.
package tx_chain_pkg;

  localparam int W = 16;

  typedef enum logic {
    IDLE = 1'b0,
    RUN  = 1'b1
  } state_e;

  // Reverses the low 'width' bits of value; bits above width come back as zero.
  function automatic logic [31:0] bitrev(input logic [31:0] value, input int width);
    logic [31:0] r;
    r = '0;
    for (int i = 0; i < width; i++) begin
      r[i] = value[width-1-i];
    end
    return r;
  endfunction

endpackage

// File: rtl/ovsf_chip_spreader_sym_fifo.sv
// DEPTH x 1-bit synchronous symbol FIFO with combinational read of the head entry.
module sym_fifo
  import tx_chain_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic clk_3p84MHz,
  input  logic reset,
  input  logic push,
  input  logic pushData,
  input  logic pop,
  output logic popData,
  output logic full,
  output logic empty
);

  localparam int AW    = $clog2(DEPTH);
  localparam int CNT_W = AW + 1;

  logic [DEPTH-1:0] mem_q;
  logic [AW-1:0]    wrPtr_q;
  logic [AW-1:0]    rdPtr_q;
  logic [CNT_W-1:0] count_q;
  logic             pushOk;
  logic             popOk;

  // A full FIFO refuses pushes even when a pop frees a slot in the same cycle.
  assign pushOk  = push && !full;
  assign popOk   = pop && !empty;
  assign full    = (count_q == CNT_W'(DEPTH));
  assign empty   = (count_q == '0);
  assign popData = mem_q[rdPtr_q];

  always_ff @(posedge clk_3p84MHz) begin
    if (!reset) begin
      mem_q   <= '0;
      wrPtr_q <= '0;
      rdPtr_q <= '0;
      count_q <= '0;
    end else begin
      if (pushOk) begin
        mem_q[wrPtr_q] <= pushData;
        wrPtr_q        <= wrPtr_q + 1'b1;
      end
      if (popOk) begin
        rdPtr_q <= rdPtr_q + 1'b1;
      end
      unique case ({pushOk, popOk})
        2'b10:   count_q <= count_q + 1'b1;
        2'b01:   count_q <= count_q - 1'b1;
        default: count_q <= count_q;
      endcase
    end
  end

endmodule

// File: rtl/ovsf_chip_spreader.sv
// Chip-rate OVSF spreader: buffers BPSK symbols, spreads each over 2^SF_LOG2
// chips with a latched OVSF code and drives a gain-scaled sample to the CIC.
module ovsf_chip_spreader
  import tx_chain_pkg::*;
#(
  parameter int SF_LOG2 = 4,
  parameter int DEPTH   = 4,
  parameter int W       = tx_chain_pkg::W
) (
  input  logic                clk_3p84MHz,
  input  logic                reset,
  input  logic                enable,
  input  logic                sym_in,
  input  logic                sym_valid,
  output logic                sym_ready,
  input  logic [SF_LOG2-1:0]  code_idx,
  input  logic [W-2:0]        gain,
  output logic signed [W-1:0] chip_out,
  output logic                sym_start,
  output logic                underflow
);

  localparam logic [SF_LOG2-1:0] SF_LAST = '1;

  state_e               state_q, state_d;
  logic [SF_LOG2-1:0]   chipCnt_q, chipCnt_d;
  logic                 sym_q, sym_d;
  logic [SF_LOG2-1:0]   code_q, code_d;
  logic [W-2:0]         gain_q, gain_d;
  logic signed [W-1:0]  chipOut_q, chipOut_d;
  logic                 symStart_q, symStart_d;
  logic                 underflow_q, underflow_d;

  logic                 fifoFull;
  logic                 fifoEmpty;
  logic                 fifoData;
  logic                 fifoPop;
  logic                 symBoundary;
  logic                 startSym;
  logic [SF_LOG2-1:0]   codeRev;
  logic                 chipBit;
  logic                 product;
  logic [W-1:0]         magnitude;

  sym_fifo #(
    .DEPTH(DEPTH)
  ) u_fifo (
    .clk_3p84MHz(clk_3p84MHz),
    .reset      (reset),
    .push       (sym_valid),
    .pushData   (sym_in),
    .pop        (fifoPop),
    .popData    (fifoData),
    .full       (fifoFull),
    .empty      (fifoEmpty)
  );

  assign sym_ready = !fifoFull;
  assign chip_out  = chipOut_q;
  assign sym_start = symStart_q;
  assign underflow = underflow_q;

  // A new symbol may only begin from idle or on the last chip of the current one.
  assign symBoundary = (state_q == IDLE) || (chipCnt_q == SF_LAST);
  assign startSym    = symBoundary && enable && !fifoEmpty;

  // Walsh-style chip: parity of the bit-reversed code index masked by the chip count.
  assign codeRev   = SF_LOG2'(bitrev(32'(code_q), SF_LOG2));
  assign chipBit   = ^(codeRev & chipCnt_q);
  assign product   = sym_q ^ chipBit;
  assign magnitude = {1'b0, gain_q};

  always_ff @(posedge clk_3p84MHz) begin
    if (!reset) begin
      state_q     <= IDLE;
      chipCnt_q   <= '0;
      sym_q       <= 1'b0;
      code_q      <= '0;
      gain_q      <= '0;
      chipOut_q   <= '0;
      symStart_q  <= 1'b0;
      underflow_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      chipCnt_q   <= chipCnt_d;
      sym_q       <= sym_d;
      code_q      <= code_d;
      gain_q      <= gain_d;
      chipOut_q   <= chipOut_d;
      symStart_q  <= symStart_d;
      underflow_q <= underflow_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    chipCnt_d = chipCnt_q;
    sym_d     = sym_q;
    code_d    = code_q;
    gain_d    = gain_q;
    if (startSym) begin
      state_d   = RUN;
      chipCnt_d = '0;
      sym_d     = fifoData;
      code_d    = code_idx;
      gain_d    = gain;
    end else begin
      unique case (state_q)
        IDLE: state_d = IDLE;
        RUN: begin
          if (chipCnt_q != SF_LAST) begin
            chipCnt_d = chipCnt_q + 1'b1;
          end else begin
            state_d   = IDLE;
            chipCnt_d = '0;
          end
        end
      endcase
    end
  end

  always_comb begin
    fifoPop     = startSym;
    chipOut_d   = '0;
    symStart_d  = 1'b0;
    underflow_d = 1'b0;
    if (state_q == RUN) begin
      chipOut_d   = product ? -magnitude : magnitude;
      symStart_d  = (chipCnt_q == '0);
      underflow_d = (chipCnt_q == SF_LAST) && enable && fifoEmpty;
    end
  end

endmodule

// File: tb/tb_ovsf_chip_spreader.sv
// Self-checking bench for ovsf_chip_spreader: hand-computed vector table, directed
// corner sequences and random traffic against a queue-based behavioural model.
module tb_ovsf_chip_spreader;

  localparam int SF    = 16;
  localparam int DEPTH = 4;

  logic               clk_3p84MHz;
  logic               reset;
  logic               enable;
  logic               sym_in;
  logic               sym_valid;
  logic               sym_ready;
  logic [3:0]         code_idx;
  logic [14:0]        gain;
  logic signed [15:0] chip_out;
  logic               sym_start;
  logic               underflow;

  ovsf_chip_spreader dut (
    .clk_3p84MHz(clk_3p84MHz),
    .reset      (reset),
    .enable     (enable),
    .sym_in     (sym_in),
    .sym_valid  (sym_valid),
    .sym_ready  (sym_ready),
    .code_idx   (code_idx),
    .gain       (gain),
    .chip_out   (chip_out),
    .sym_start  (sym_start),
    .underflow  (underflow)
  );

  initial begin
    clk_3p84MHz = 1'b0;
    forever #5 clk_3p84MHz = ~clk_3p84MHz;
  end

  typedef struct {
    logic        rst;
    logic        en;
    logic        valid;
    logic        sym;
    logic [3:0]  code;
    logic [14:0] gain;
    int          out;
    logic        start;
    logic        ready;
    logic        under;
  } vec_t;

  vec_t vecs[10];

  int nChecks = 0;
  int nErrors = 0;

  // OVSF code tree: row k is code C(SF,k) as 0 (+1) / 1 (-1) chips
  int ovsf[SF][SF];

  bit mq[$];
  bit mActive;
  int mIdx;
  bit mSym;
  int mCode;
  int mGain;
  int expOut;
  bit expStart;
  bit expUnder;
  bit expReady;

  int tallyVal;
  int posCnt;
  int negCnt;
  int startCnt;
  int underCnt;

  task automatic buildOvsf();
    int tmp[SF][SF];
    int len;
    ovsf[0][0] = 0;
    len = 1;
    while (len < SF) begin
      for (int k = 0; k < len; k++) begin
        for (int n = 0; n < len; n++) begin
          tmp[2*k][n]         = ovsf[k][n];
          tmp[2*k][n+len]     = ovsf[k][n];
          tmp[2*k+1][n]       = ovsf[k][n];
          tmp[2*k+1][n+len]   = 1 - ovsf[k][n];
        end
      end
      ovsf = tmp;
      len  = len * 2;
    end
  endtask

  task automatic modelStep(input bit rst, input bit en, input bit valid, input bit sym,
                           input int code, input int gn);
    int preSize;
    if (!rst) begin
      mq.delete();
      mActive  = 0;
      mIdx     = 0;
      mSym     = 0;
      mCode    = 0;
      mGain    = 0;
      expOut   = 0;
      expStart = 0;
      expUnder = 0;
      expReady = 1;
      return;
    end
    preSize = mq.size();
    if (mActive) begin
      expOut   = ((mSym ? 1 : 0) ^ ovsf[mCode][mIdx]) != 0 ? -mGain : mGain;
      expStart = (mIdx == 0);
      expUnder = (mIdx == SF - 1) && en && (preSize == 0);
    end else begin
      expOut   = 0;
      expStart = 0;
      expUnder = 0;
    end
    if (mActive && mIdx < SF - 1) begin
      mIdx++;
    end else if (en && preSize > 0) begin
      mSym    = mq.pop_front();
      mCode   = code;
      mGain   = gn;
      mIdx    = 0;
      mActive = 1;
    end else begin
      mActive = 0;
    end
    if (valid && preSize < DEPTH) mq.push_back(sym);
    expReady = (mq.size() < DEPTH);
  endtask

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    nChecks++;
    if (act !== exp) begin
      nErrors++;
      $display("[TB] FAIL %s: got %0d expected %0d", name, $signed(act), $signed(exp));
    end
  endtask

  task automatic applyStimulus(input bit rst, input bit en, input bit valid, input bit sym,
                               input logic [3:0] code, input logic [14:0] gn);
    reset     = rst;
    enable    = en;
    sym_valid = valid;
    sym_in    = sym;
    code_idx  = code;
    gain      = gn;
    modelStep(rst, en, valid, sym, int'(code), int'(gn));
    @(posedge clk_3p84MHz);
    #1;
  endtask

  task automatic checkOutput(input string name);
    check({name, ".chip_out"}, 32'(chip_out), 32'(expOut));
    check({name, ".sym_start"}, 32'(sym_start), 32'(expStart));
    check({name, ".underflow"}, 32'(underflow), 32'(expUnder));
    check({name, ".sym_ready"}, 32'(sym_ready), 32'(expReady));
    if (int'(chip_out) == tallyVal) posCnt++;
    else if (int'(chip_out) == -tallyVal) negCnt++;
    if (sym_start === 1'b1) startCnt++;
    if (underflow === 1'b1) underCnt++;
  endtask

  task automatic clearTally(input int val);
    tallyVal = val;
    posCnt   = 0;
    negCnt   = 0;
    startCnt = 0;
    underCnt = 0;
  endtask

  task automatic runSeq(input int n, input bit rst, input bit en, input bit valid, input bit sym,
                        input logic [3:0] code, input logic [14:0] gn, input string name);
    for (int i = 0; i < n; i++) begin
      applyStimulus(rst, en, valid, sym, code, gn);
      checkOutput(name);
    end
  endtask

  initial begin
    reset     = 1'b0;
    enable    = 1'b0;
    sym_valid = 1'b0;
    sym_in    = 1'b0;
    code_idx  = '0;
    gain      = '0;
    buildOvsf();
    clearTally(1);

    // Reset with valid held, one push, then a code-2 symbol whose code/gain change mid-symbol
    vecs[0] = '{1'b0, 1'b0, 1'b1, 1'b0, 4'd0, 15'd0,   0,    1'b0, 1'b1, 1'b0};
    vecs[1] = '{1'b0, 1'b0, 1'b1, 1'b0, 4'd0, 15'd0,   0,    1'b0, 1'b1, 1'b0};
    vecs[2] = '{1'b0, 1'b0, 1'b1, 1'b0, 4'd0, 15'd0,   0,    1'b0, 1'b1, 1'b0};
    vecs[3] = '{1'b1, 1'b0, 1'b1, 1'b1, 4'd0, 15'd500, 0,    1'b0, 1'b1, 1'b0};
    vecs[4] = '{1'b1, 1'b1, 1'b0, 1'b0, 4'd2, 15'd500, 0,    1'b0, 1'b1, 1'b0};
    vecs[5] = '{1'b1, 1'b1, 1'b0, 1'b0, 4'd0, 15'd7,   -500, 1'b1, 1'b1, 1'b0};
    vecs[6] = '{1'b1, 1'b1, 1'b0, 1'b0, 4'd0, 15'd7,   -500, 1'b0, 1'b1, 1'b0};
    vecs[7] = '{1'b1, 1'b1, 1'b0, 1'b0, 4'd0, 15'd7,   -500, 1'b0, 1'b1, 1'b0};
    vecs[8] = '{1'b1, 1'b1, 1'b0, 1'b0, 4'd0, 15'd7,   -500, 1'b0, 1'b1, 1'b0};
    vecs[9] = '{1'b1, 1'b1, 1'b0, 1'b0, 4'd0, 15'd7,   500,  1'b0, 1'b1, 1'b0};

    for (int v = 0; v < 10; v++) begin
      applyStimulus(vecs[v].rst, vecs[v].en, vecs[v].valid, vecs[v].sym, vecs[v].code, vecs[v].gain);
      check($sformatf("vec%0d.chip_out", v), 32'(chip_out), 32'(vecs[v].out));
      check($sformatf("vec%0d.sym_start", v), 32'(sym_start), 32'(vecs[v].start));
      check($sformatf("vec%0d.sym_ready", v), 32'(sym_ready), 32'(vecs[v].ready));
      check($sformatf("vec%0d.underflow", v), 32'(underflow), 32'(vecs[v].under));
    end

    // Basic spread: two gapless symbols then underflow into idle
    runSeq(3, 0, 0, 1, 0, 4'd0, 15'd1000, "reset");
    runSeq(1, 1, 0, 1, 0, 4'd0, 15'd1000, "push0");
    runSeq(1, 1, 0, 1, 1, 4'd0, 15'd1000, "push1");
    clearTally(1000);
    runSeq(40, 1, 1, 0, 0, 4'd0, 15'd1000, "basic");
    check("basic.pos", 32'(posCnt), 32'd16);
    check("basic.neg", 32'(negCnt), 32'd16);
    check("basic.starts", 32'(startCnt), 32'd2);
    check("basic.underflows", 32'(underCnt), 32'd1);

    // OVSF codes 1 and 3
    runSeq(1, 1, 0, 1, 0, 4'd1, 15'd200, "push_c1");
    clearTally(200);
    runSeq(20, 1, 1, 0, 0, 4'd1, 15'd200, "code1");
    check("code1.pos", 32'(posCnt), 32'd8);
    check("code1.neg", 32'(negCnt), 32'd8);
    runSeq(1, 1, 0, 1, 0, 4'd3, 15'd200, "push_c3");
    runSeq(20, 1, 1, 0, 0, 4'd3, 15'd200, "code3");

    // Backpressure: fill, refuse a fifth push, then drain in order
    runSeq(1, 1, 0, 1, 1, 4'd0, 15'd300, "fill");
    runSeq(1, 1, 0, 1, 0, 4'd0, 15'd300, "fill");
    runSeq(1, 1, 0, 1, 1, 4'd0, 15'd300, "fill");
    runSeq(1, 1, 0, 1, 1, 4'd0, 15'd300, "fill");
    check("full.sym_ready", 32'(sym_ready), 32'd0);
    runSeq(1, 1, 0, 1, 0, 4'd0, 15'd300, "refused");
    check("refused.sym_ready", 32'(sym_ready), 32'd0);
    clearTally(300);
    runSeq(70, 1, 1, 0, 0, 4'd0, 15'd300, "drain");
    check("drain.starts", 32'(startCnt), 32'd4);
    check("drain.pos", 32'(posCnt), 32'd16);
    check("drain.neg", 32'(negCnt), 32'd48);

    // Enable drop mid-symbol: symbol completes, no underflow, FIFO keeps the rest
    runSeq(1, 1, 0, 1, 0, 4'd0, 15'd400, "dpush");
    runSeq(1, 1, 0, 1, 1, 4'd0, 15'd400, "dpush");
    runSeq(1, 1, 0, 1, 0, 4'd0, 15'd400, "dpush");
    clearTally(400);
    runSeq(7, 1, 1, 0, 0, 4'd0, 15'd400, "drop_run");
    runSeq(20, 1, 0, 0, 0, 4'd0, 15'd400, "drop_idle");
    check("drop.starts", 32'(startCnt), 32'd1);
    check("drop.pos", 32'(posCnt), 32'd16);
    check("drop.underflows", 32'(underCnt), 32'd0);
    runSeq(40, 1, 1, 0, 0, 4'd0, 15'd400, "drop_resume");
    check("resume.starts", 32'(startCnt), 32'd3);

    // Reset mid-symbol aborts the symbol and empties the FIFO
    runSeq(1, 1, 0, 1, 1, 4'd0, 15'd32767, "rpush");
    runSeq(1, 1, 0, 1, 0, 4'd0, 15'd32767, "rpush");
    runSeq(9, 1, 1, 0, 0, 4'd0, 15'd32767, "rrun");
    runSeq(1, 0, 1, 0, 0, 4'd0, 15'd32767, "rmid");
    check("rmid.chip_out", 32'(chip_out), 32'd0);
    clearTally(32767);
    runSeq(10, 1, 1, 0, 0, 4'd0, 15'd32767, "rafter");
    check("rafter.starts", 32'(startCnt), 32'd0);

    // Maximum gain with p=1
    runSeq(1, 1, 0, 1, 1, 4'd0, 15'd32767, "maxpush");
    clearTally(32767);
    runSeq(20, 1, 1, 0, 0, 4'd0, 15'd32767, "maxgain");
    check("maxgain.neg", 32'(negCnt), 32'd16);

    // Random traffic against the model
    for (int i = 0; i < 3000; i++) begin
      applyStimulus($urandom_range(0, 199) != 0, $urandom_range(0, 9) < 7,
                    $urandom_range(0, 1) == 1, $urandom_range(0, 1) == 1,
                    4'($urandom_range(0, 15)), 15'($urandom_range(0, 32767)));
      checkOutput("random");
    end

    $display("Result: errors=%0d of %0d checks", nErrors, nChecks);
    $finish;
  end

endmodule
